// File: rtl/flp_mult_stream_adapter_if.sv
// Handshake/bus bundle between the stream adapter, its upstream/downstream
// consumers and the pipelined FP multiplier.
interface flp_mult_stream_adapter_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              mult_start;
  logic [DATA_W-1:0] mult_a;
  logic [DATA_W-1:0] mult_b;
  logic [DATA_W-1:0] mult_result;
  logic              mult_done;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              err_sticky;

  // Adapter-side view.
  modport slave (
    input  in_valid, in_a, in_b, in_tag, mult_result, mult_done, out_ready,
    output in_ready, mult_start, mult_a, mult_b, out_valid, out_data, out_tag,
           err_sticky
  );

  // Environment-side view (producer, consumer and multiplier together).
  modport master (
    output in_valid, in_a, in_b, in_tag, mult_result, mult_done, out_ready,
    input  in_ready, mult_start, mult_a, mult_b, out_valid, out_data, out_tag,
           err_sticky
  );
endinterface

// File: rtl/flp_mult_stream_adapter.sv
// Valid/ready wrapper around a fixed-latency FP multiplier: tags ride a shift
// pipeline beside the multiplier and results land in a credit-protected FIFO.
module flp_mult_stream_adapter #(
  parameter int DATA_W       = 64,
  parameter int TAG_W        = 8,
  parameter int MULT_LATENCY = 5,
  parameter int FIFO_DEPTH   = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  flp_mult_stream_adapter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(MULT_LATENCY + 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] SETTLE_C = SW'(MULT_LATENCY);

  logic [SW-1:0]                    settle_q, settle_d;
  logic [AW:0]                      used_q, used_d;
  logic [AW:0]                      wr_ptr_q, rd_ptr_q, occ;
  logic [MULT_LATENCY:1]            vld_pipe_q;
  logic [MULT_LATENCY:1][TAG_W-1:0] tag_pipe_q;
  logic [DATA_W-1:0]                mem_data_q [FIFO_DEPTH];
  logic [TAG_W-1:0]                 mem_tag_q  [FIFO_DEPTH];
  logic err_q, settled, in_ready, fire, pop, wr_en, full, empty, piped_vld;

  assign settled   = (settle_q == '0);
  assign in_ready  = settled && (used_q < DEPTH_C);
  assign fire      = bus.in_valid && in_ready;
  assign piped_vld = vld_pipe_q[MULT_LATENCY];

  assign occ   = wr_ptr_q - rd_ptr_q;
  assign full  = (occ == DEPTH_C);
  assign empty = (occ == '0);
  assign pop   = !empty && bus.out_ready;
  // A piped valid with a missing done still writes so tags stay in order;
  // the full guard only matters after an alignment error (spurious done).
  assign wr_en = settled && (bus.mult_done || piped_vld) && !full;

  assign bus.in_ready   = in_ready;
  assign bus.mult_start = fire;
  assign bus.mult_a     = bus.in_a;
  assign bus.mult_b     = bus.in_b;
  assign bus.out_valid  = !empty;
  assign bus.out_data   = mem_data_q[rd_ptr_q[AW-1:0]];
  assign bus.out_tag    = mem_tag_q[rd_ptr_q[AW-1:0]];
  assign bus.err_sticky = err_q;

  always_comb begin
    settle_d = settled ? settle_q : settle_q - 1'b1;
    used_d   = used_q;
    case ({fire, pop})
      2'b10:   used_d = used_q + 1'b1;
      2'b01:   used_d = used_q - 1'b1;
      default: used_d = used_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= SETTLE_C;
      used_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      settle_q <= settle_d;
      used_q   <= used_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (settled && (bus.mult_done != piped_vld)) err_q <= 1'b1;
    end
  end

  // Stage MULT_LATENCY lines up with the multiplier's done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= fire;
      tag_pipe_q[1] <= bus.in_tag;
      for (int s = 2; s <= MULT_LATENCY; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        tag_pipe_q[s] <= tag_pipe_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data_q[wr_ptr_q[AW-1:0]] <= bus.mult_result;
      mem_tag_q[wr_ptr_q[AW-1:0]]  <= tag_pipe_q[MULT_LATENCY];
    end
  end
endmodule

// File: doc/flp_mult_stream_adapter.md
Name: flp_mult_stream_adapter

Overview:
- Streaming front/back end for the pipelined FP multiplier (fixed latency, no backpressure, unbuffered inputs, buffered `result`/`done`).
- Upstream side: accepts operand pairs with a tag over a valid/ready handshake and drives the multiplier's `start`/`a`/`b`.
- Downstream side: captures every `done`/`result` into a credit-protected FIFO and presents it, with its tag, over valid/ready.
- Downstream consumers can stall without losing a multiplier result.

Parameters:
- DATA_W, 64, floating-point word width (`OVERALL_BITS`).
- TAG_W, 8, opaque tag carried alongside each operation.
- MULT_LATENCY, 5, cycles from multiplier `start` to `done`.
- FIFO_DEPTH, 8, result FIFO entries; power of two, must be >= MULT_LATENCY+2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  adapter can accept
- in_a  in  DATA_W  operand a
- in_b  in  DATA_W  operand b
- in_tag  in  TAG_W  tag
- mult_start  out  1  to multiplier `start`
- mult_a  out  DATA_W  to multiplier `a`
- mult_b  out  DATA_W  to multiplier `b`
- mult_result  in  DATA_W  from multiplier `result`
- mult_done  in  1  from multiplier `done`
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  DATA_W  product
- out_tag  out  TAG_W  tag of product
- err_sticky  out  1  alignment error seen

Behaviour:
- Reset: one clock `clk`; reset is asynchronous and active-low (`rst_n`). Reset clears:
  - used counter = 0, FIFO pointers = 0, tag/valid shift pipeline = 0, err_sticky = 0;
  - settle counter loaded to MULT_LATENCY.
- Outputs during reset: in_ready = 0, out_valid = 0, mult_start = 0.
- Settle phase: while settle != 0, decrement each cycle, hold in_ready = 0, and ignore mult_done. This discards stale `done` pulses from the unreset multiplier pipeline. Reset asserted mid-operation drops all in-flight and buffered results.
- Issue:
  - in_ready = (settle == 0) && (used < FIFO_DEPTH); registered terms only, no combinational path from out_ready.
  - fire = in_valid && in_ready.
  - mult_start = fire; mult_a = in_a, mult_b = in_b (combinational pass-through; the multiplier registers them).
- Tag pipeline: MULT_LATENCY-stage shift register of {fire, in_tag}. The stage-MULT_LATENCY entry aligns with mult_done.
- Capture: on (settle == 0) && mult_done, write {mult_result, piped tag} at the write pointer and increment it (wraps mod FIFO_DEPTH).
- Alignment check: if mult_done != piped valid (and settle == 0), set err_sticky. In the case "piped valid without done", still write the piped tag with mult_result so the tag stream stays ordered.
- Output: out_valid = FIFO not empty. out_data/out_tag come from the head entry (register-array read). pop = out_valid && out_ready increments the read pointer.
- used counter:
  - +1 on fire, -1 on pop, unchanged when both occur.
  - Counts in-flight plus buffered results, so the FIFO can never overflow; range 0..FIFO_DEPTH.
- Empty/full: full and empty are derived from a pointer-difference occupancy of width log2(FIFO_DEPTH)+1.
  - Simultaneous write and pop on empty: no bypass; the data appears next cycle.
  - Simultaneous write and pop on nonempty: occupancy unchanged.
- Latency: accept at cycle t -> mult_done at t+MULT_LATENCY -> out_valid at t+MULT_LATENCY+1 (6 cycles at default).
- Throughput: one op per cycle sustained while out_ready = 1.
- Ordering: results leave strictly in issue order, with tags preserved.

Test Plan:
1. Reset release: in_ready stays 0 for exactly 5 cycles, then goes to 1. Inject a mult_done pulse during settle -> out_valid stays 0 and err_sticky stays 0.
2. Single op: a = 0x4000000000000000 (2.0), b = 0x4008000000000000 (3.0), tag 0x2A, accepted at cycle t. With the real multiplier attached, out_valid rises at t+6 with out_data = 0x4018000000000000 and out_tag = 0x2A.
3. Back-to-back: 20 ops with tags 0..19 and out_ready held at 1 -> in_ready never drops. Outputs arrive in order on 20 consecutive cycles starting 6 cycles after the first accept.
4. Backpressure: out_ready = 0 while issuing continuously -> exactly 8 ops are accepted, then in_ready = 0. Raising out_ready later delivers all 8 in order with no loss, and in_ready returns 1 the cycle after the first pop.
5. Alignment fault: stub multiplier drops one done pulse -> err_sticky = 1 and stays 1 until rst_n is asserted.
6. Mid-stream reset: assert rst_n low with 3 results in flight and 4 buffered -> out_valid = 0 immediately. After release plus the 5-cycle settle, no stale results appear.
